// File: rtl/rsc_frame_encoder.sv
// rsc_frame_encoder: rate-1/2 (7,5) RSC encoder with FRAME_LEN-bit framing and a one-entry output register.
// Define RSC_TERM_EN to append two trellis-terminating tail pairs to each frame.
module rsc_frame_encoder #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_bit,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic out_sys,
  output logic out_par,
  output logic out_last,
  output logic busy
);
`ifdef RSC_TERM_EN
  typedef enum logic [1:0] {IDLE, DATA, TERM} state_t;
`else
  typedef enum logic {IDLE, DATA} state_t;
`endif
  state_t state_q, state_d;
  logic s1_q, s1_d, s2_q, s2_d;
  logic ov_q, ov_d, sys_q, sys_d, par_q, par_d, last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
  logic free, in_xfer, frame_end;
`ifdef RSC_TERM_EN
  logic tail_q, tail_d;
  assign in_ready = (state_q != TERM) && free;
`else
  assign in_ready = free;
`endif
  assign free      = !ov_q || out_ready;
  assign in_xfer   = in_valid && in_ready;
  assign cnt_nxt   = (state_q == IDLE) ? CNT_W'(1) : cnt_q + 1'b1;
  assign frame_end = cnt_nxt == CNT_W'(FRAME_LEN);
  assign busy      = state_q != IDLE;
  assign out_valid = ov_q;
  assign out_sys   = sys_q;
  assign out_par   = par_q;
  assign out_last  = last_q;
  always_comb begin
    state_d = state_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q && !out_ready;
    sys_d   = sys_q;
    par_d   = par_q;
    last_d  = last_q;
`ifdef RSC_TERM_EN
    tail_d  = tail_q;
`endif
    if (in_xfer) begin
      ov_d    = 1'b1;
      sys_d   = in_bit;
      par_d   = in_bit ^ s1_q;
      s1_d    = in_bit ^ s1_q ^ s2_q;
      s2_d    = s1_q;
      cnt_d   = cnt_nxt;
      last_d  = 1'b0;
      state_d = DATA;
      if (frame_end) begin
`ifdef RSC_TERM_EN
        state_d = TERM;
`else
        state_d = IDLE;
        s1_d    = 1'b0;
        s2_d    = 1'b0;
        cnt_d   = '0;
        last_d  = 1'b1;
`endif
      end
    end
`ifdef RSC_TERM_EN
    // tail input u = s1^s2 forces the feedback sum to zero, flushing the register in two steps
    else if (state_q == TERM && free) begin
      ov_d   = 1'b1;
      sys_d  = s1_q ^ s2_q;
      par_d  = s2_q;
      s1_d   = 1'b0;
      s2_d   = s1_q;
      last_d = tail_q;
      tail_d = !tail_q;
      if (tail_q) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
`endif
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      sys_q   <= 1'b0;
      par_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      sys_q   <= sys_d;
      par_q   <= par_d;
      last_q  <= last_d;
    end
  end
`ifdef RSC_TERM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tail_q <= 1'b0;
    else      tail_q <= tail_d;
  end
`endif
endmodule

// File: tb/tb_rsc_frame_encoder.sv
// tb_rsc_frame_encoder: directed + random frames checked against a sequence-level (7,5) RSC model.
module tb_rsc_frame_encoder;
  localparam int FL = 16;
`ifdef RSC_TERM_EN
  localparam bit TERM = 1'b1;
`else
  localparam bit TERM = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, in_valid, in_bit, in_ready, out_valid, out_ready, out_sys, out_par, out_last, busy;
  int n_cmp = 0, n_err = 0;
  logic [2:0] expq[$];
  int pos = 0, tail_left = 0;
  logic ov_m = 1'b0, stall_prev = 1'b0;
  logic [2:0] held;

  rsc_frame_encoder #(.FRAME_LEN(FL), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_sys(out_sys), .out_par(out_par),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-frame model: feedback sequence a[k] = u[k]^a[k-1]^a[k-2], parity = a[k]^a[k-2]
  task automatic enqueue(input logic [FL-1:0] fr);
    logic a[FL+2];
    logic u, p, am1, am2;
    int n;
    n = TERM ? FL + 2 : FL;
    for (int k = 0; k < n; k++) begin
      am1 = (k >= 1) ? a[k-1] : 1'b0;
      am2 = (k >= 2) ? a[k-2] : 1'b0;
      if (k < FL) begin
        u = fr[k];
        a[k] = u ^ am1 ^ am2;
      end else begin
        u = am1 ^ am2;
        a[k] = 1'b0;
      end
      p = a[k] ^ am2;
      expq.push_back({u, p, k == n - 1});
    end
  endtask

  task automatic step(input logic v, input logic b, input logic r, output logic acc);
    logic rdy_m, prod;
    logic [2:0] o;
    in_valid = v;
    in_bit = b;
    out_ready = r;
    #1;
    rdy_m = (tail_left == 0) && (!ov_m || r);
    chk("in_ready", in_ready, rdy_m);
    chk("out_valid", out_valid, ov_m);
    chk("busy", busy, (pos > 0) || (tail_left > 0));
    o = {out_sys, out_par, out_last};
    if (stall_prev) chk("hold", o, held);
    stall_prev = ov_m && !r;
    held = o;
    if (ov_m && r) begin
      n_cmp++;
      assert (expq.size() > 0) else begin
        n_err++;
        $error("FAIL pair_extra observed=%0h expected=none", o);
      end
      if (expq.size() > 0) chk("pair", o, expq.pop_front());
    end
    acc = v && rdy_m;
    prod = acc;
    if (acc) begin
      pos++;
      if (pos == FL) begin
        pos = 0;
        tail_left = TERM ? 2 : 0;
      end
    end else if (tail_left > 0 && (!ov_m || r)) begin
      prod = 1'b1;
      tail_left--;
    end
    ov_m = prod || (ov_m && !r);
    @(negedge clk);
  endtask

  // mode 0: full rate; 1: random valid/ready; 2: out_ready low for 3 cycles mid-frame
  task automatic run_frame(input logic [FL-1:0] fr, input int nmax, input int mode);
    logic acc, v, r;
    int cnt, c;
    enqueue(fr);
    cnt = 0;
    c = 0;
    while (cnt < nmax && c < 2000) begin
      v = (mode == 1) ? ($urandom % 5 != 0) : 1'b1;
      r = (mode == 1) ? ($urandom % 10 < 7) : !(mode == 2 && c >= 5 && c < 8);
      step(v, fr[pos], r, acc);
      if (acc) cnt++;
      c++;
    end
    chk("frame_timeout", cnt, nmax);
  endtask

  task automatic drain();
    logic acc;
    int c;
    c = 0;
    while ((expq.size() > 0 || tail_left > 0 || ov_m) && c < 200) begin
      step(1'b0, 1'b0, 1'b1, acc);
      c++;
    end
    chk("drain_left", expq.size(), 0);
  endtask

  initial begin
    logic [FL-1:0] imp, rnd;
    imp = '0;
    imp[0] = 1'b1;
    rst = 1'b0;
    in_valid = 1'b0;
    in_bit = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_outs", {out_valid, out_sys, out_par, out_last}, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    run_frame(imp, FL, 0);
    drain();
    run_frame('0, FL, 0);
    drain();
    run_frame(imp, FL, 2);
    drain();
    run_frame(imp, FL, 0);
    run_frame(imp, FL, 0);
    drain();
    run_frame(imp, 2, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    expq.delete();
    pos = 0;
    tail_left = 0;
    ov_m = 1'b0;
    stall_prev = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_frame(imp, FL, 0);
    drain();
    for (int i = 0; i < 6; i++) begin
      rnd = FL'({$urandom, $urandom});
      run_frame(rnd, FL, (i % 2 == 0) ? 1 : 2);
    end
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
